// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle control FSM; define MULDIV_EN to enable the mul/div execute path
module multicycle_control #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  input  logic        md_done,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic        pc_write,
  output logic        ir_load,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_a_sel,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic [2:0]  branch_f3,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [7:0] LIM = 8'(TIMEOUT_CYC - 1);
  logic [31:0] ir;
  logic [7:0] cnt;
  logic [2:0] nxt, f3;
  logic [1:0] cause_nxt;
  logic [6:0] opc, f7;
  logic [3:0] alu_f;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_md, md_ok;
  logic legal, waiting, timeout, act, unused_ir;
  assign opc = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign unused_ir = ^ir[24:15];
  assign is_r = opc == OP_R;
  assign is_i = opc == OP_I;
  assign is_ld = opc == OP_LD;
  assign is_st = opc == OP_ST;
  assign is_br = opc == OP_BR;
  assign is_jal = opc == OP_JAL;
  assign is_jalr = opc == OP_JALR;
  assign is_lui = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_md = is_r && f7 == 7'b0000001;
  assign legal = (is_r && (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) || (is_md && md_ok)))
              || (is_i && (f3 == 3'd1 ? f7 == 7'd0 : f3 == 3'd5 ? (f7 == 7'd0 || f7 == 7'b0100000) : 1'b1))
              || (is_ld && f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)
              || (is_st && f3 < 3'd3)
              || (is_br && f3 != 3'd2 && f3 != 3'd3)
              || (is_jalr && f3 == 3'd0)
              || is_jal || is_lui || is_auipc;
  // only register-register ops may select SUB/SRA via func7; for immediates ir[30] is an imm bit except on shifts
  assign alu_f = f3 == 3'd0 ? (is_r && f7[5] ? 4'd1 : 4'd0) :
                 f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 : f3 == 3'd4 ? 4'd7 :
                 f3 == 3'd5 ? (f7[5] ? 4'd5 : 4'd6) : f3 == 3'd6 ? 4'd8 : 4'd9;
  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  assign timeout = waiting && cnt == LIM;
  always_comb begin
    nxt = state;
    cause_nxt = trap_cause;
    case (state)
      FETCH: if (imem_ready) nxt = DECODE; else if (timeout) {nxt, cause_nxt} = {TRAP, 2'd2};
      DECODE: {nxt, cause_nxt} = legal ? {EXEC, trap_cause} : {TRAP, 2'd1};
      EXEC: nxt = is_br ? FETCH : (is_ld || is_st) ? MEM : (is_md && !md_done) ? EXEC : WB;
      MEM: if (dmem_ready) nxt = is_ld ? WB : FETCH; else if (timeout) {nxt, cause_nxt} = {TRAP, 2'd3};
      WB: nxt = FETCH;
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      ir <= '0;
      cnt <= '0;
      trap_cause <= '0;
    end else begin
      state <= nxt;
      trap_cause <= cause_nxt;
      cnt <= waiting ? cnt + 8'd1 : 8'd0;
      if (ir_load) ir <= instr;
    end
`ifdef MULDIV_EN
  logic md_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) md_busy <= 1'b0;
    else md_busy <= state == EXEC && is_md && !md_done;
  assign md_ok = 1'b1;
  assign md_start = state == EXEC && is_md && !md_busy;
  assign md_op = state == EXEC && is_md ? f3 : 3'd0;
`else
  assign md_ok = 1'b0;
  assign md_start = 1'b0;
  assign md_op = 3'd0;
`endif
  assign act = state == EXEC || state == MEM || state == WB;
  assign imem_req = state == FETCH && !rst;
  assign ir_load = state == FETCH && imem_ready && !rst;
  assign dmem_req = state == MEM;
  assign dmem_we = state == MEM && is_st;
  assign reg_write = state == WB && ir[11:7] != 5'd0;
  assign pc_write = (state == EXEC && is_br) || (state == MEM && is_st && dmem_ready) || state == WB;
  assign pc_src = state == EXEC && is_br ? {1'b0, branch_taken} :
                  state == WB ? (is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0) : 2'd0;
  assign alu_op = act && (is_r || is_i) ? alu_f : 4'd0;
  assign alu_a_sel = !act ? 2'd0 : is_lui ? 2'd2 : (is_auipc || is_jal) ? 2'd1 : 2'd0;
  assign alu_src_imm = act && !is_r && !is_br;
  assign wb_sel = state != WB ? 2'd0 : is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_md ? 2'd3 : 2'd0;
  assign branch_f3 = state == EXEC && is_br ? f3 : 3'd0;
  assign trap = state == TRAP;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench; expected control events are queued per instruction
module tb_multicycle_control;
  logic clk, rst, imem_ready, dmem_ready, branch_taken, md_done;
  logic [31:0] instr;
  logic imem_req, dmem_req, dmem_we, reg_write, pc_write, ir_load, alu_src_imm, md_start, trap;
  logic [1:0] pc_src, alu_a_sel, wb_sel, trap_cause;
  logic [3:0] alu_op;
  logic [2:0] branch_f3, md_op, state;
  typedef struct packed {
    logic [2:0] st; logic rw; logic pw; logic [1:0] ps; logic [1:0] ws; logic [3:0] aop;
    logic [1:0] asel; logic si; logic we; logic [2:0] bf; logic ms; logic [2:0] mo;
    logic tr; logic [1:0] tc; logic dq;
  } ev_t;
  ev_t exp_q[$];
  string tag_q[$];
  int nt = 0, nf = 0, dreq_n = 0, ireq_n = 0;
  logic [31:0] trace_w = 0;
  localparam logic [31:0] ADD = 32'h003100B3, SUB = 32'h407302B3, SRAI = 32'h40325213, ADDI0 = 32'h40008013;
  localparam logic [31:0] SLTU = 32'h0041B133, LW = 32'h0000A103, SW = 32'h0020A223, BEQ = 32'h00208463;
  localparam logic [31:0] BNE = 32'h00209463, JAL = 32'h010000EF, JALR = 32'h00008067, LUI = 32'h123451B7;
  localparam logic [31:0] AUIPC = 32'h00001197, MUL = 32'h023100B3, DIV = 32'h023140B3, BADF7 = 32'h40001033;
  multicycle_control #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .md_done(md_done), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write(reg_write), .pc_write(pc_write), .ir_load(ir_load),
    .pc_src(pc_src), .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_src_imm(alu_src_imm),
    .wb_sel(wb_sel), .branch_f3(branch_f3), .md_start(md_start), .md_op(md_op),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic ev_t mk(int st, int rw, int pw, int ps, int ws, int aop, int asel, int si,
                             int we, int bf, int ms, int mo, int tr, int tc, int dq);
    ev_t e;
    e = '{3'(st), 1'(rw), 1'(pw), 2'(ps), 2'(ws), 4'(aop), 2'(asel), 1'(si), 1'(we), 3'(bf),
          1'(ms), 3'(mo), 1'(tr), 2'(tc), 1'(dq)};
    return e;
  endfunction
  function automatic ev_t wbev(int rw, int ps, int ws, int aop, int asel, int si);
    return mk(4, rw, 1, ps, ws, aop, asel, si, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic ev_t trapev(int tc);
    return mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tc, 0);
  endfunction
  task automatic expect_ev(string t, ev_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nt++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask
  // any strobe, a completed dmem handshake or trap entry is an observable event
  task automatic monitor();
    ev_t a, e;
    string t;
    logic ptr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) ptr = 1'b0;
      else begin
        trace_w = {trace_w[27:0], 1'b0, state};
        dreq_n += int'(dmem_req);
        ireq_n += int'(imem_req);
        if (pc_write || reg_write || md_start || (dmem_req && dmem_ready) || (trap && !ptr)) begin
          a = {state, reg_write, pc_write, pc_src, wb_sel, alu_op, alu_a_sel, alu_src_imm, dmem_we,
               branch_f3, md_start, md_op, trap, trap_cause, dmem_req};
          nt++;
          if (exp_q.size() == 0) begin
            nf++;
            $display("FAIL unexpected_event: got %h, expected none", a);
          end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (a !== e) begin
              nf++;
              $display("FAIL %s: got %h, expected %h", t, a, e);
            end
          end
        end
        ptr = trap;
      end
    end
  endtask
  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic tk, input int mw);
    int wi = 0, wd = 0, wm = 0;
    bit f = 0;
    for (int c = 0; c < 200; c++) begin
      instr = ins; branch_taken = tk; imem_ready = 0; dmem_ready = 0; md_done = 0;
      if (state == 3'd5 || (state == 3'd0 && f)) return;
      if (state == 3'd0) begin imem_ready = wi == iw; f = imem_ready; wi++; end
      else if (state == 3'd3) begin dmem_ready = wd == dw; wd++; end
      else if (state == 3'd2) begin md_done = wm == mw; wm++; end
      @(posedge clk); #1;
    end
    nt++; nf++;
    $display("FAIL run_budget: instr %h never completed", ins);
  endtask
  task automatic trap_reset(string n);
    @(negedge clk); @(posedge clk); #1;
    chk({n, "_sticky"}, 32'(state), 5);
    rst = 1; #1;
    chk({n, "_rst_state"}, 32'({state, trap, trap_cause}), 0);
    chk({n, "_rst_strobes"}, 32'({imem_req, dmem_req, reg_write, pc_write, ir_load}), 0);
    @(posedge clk); #1; rst = 0; #1;
    chk({n, "_imem_req"}, 32'(imem_req), 1);
  endtask
  initial begin
    rst = 1; instr = 0; imem_ready = 0; dmem_ready = 0; branch_taken = 0; md_done = 0;
    fork monitor(); join_none
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_trap", 32'({trap, trap_cause}), 0);
    chk("reset_strobes", 32'({imem_req, dmem_req, dmem_we, reg_write, pc_write, ir_load, md_start}), 0);
    @(posedge clk); #1; rst = 0; #1;
    chk("release_imem_req", 32'(imem_req), 1);
    trace_w = 0;
    expect_ev("add_wb", wbev(1, 0, 0, 0, 0, 0));
    run(ADD, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("add_state_trace", trace_w, 32'h00001240);
    @(posedge clk); #1;
    expect_ev("sub_wb", wbev(1, 0, 0, 1, 0, 0));
    run(SUB, 0, 0, 0, 0);
    expect_ev("srai_wb", wbev(1, 0, 0, 5, 0, 1));
    run(SRAI, 0, 0, 0, 0);
    expect_ev("addi_x0_wb", wbev(0, 0, 0, 0, 0, 1));
    run(ADDI0, 0, 0, 0, 0);
    expect_ev("sltu_wb", wbev(1, 0, 0, 4, 0, 0));
    run(SLTU, 0, 0, 0, 0);
    expect_ev("lui_wb", wbev(1, 0, 0, 0, 2, 1));
    run(LUI, 0, 0, 0, 0);
    expect_ev("auipc_wb", wbev(1, 0, 0, 0, 1, 1));
    run(AUIPC, 0, 0, 0, 0);
    expect_ev("jal_wb", wbev(1, 1, 2, 0, 1, 1));
    run(JAL, 0, 0, 0, 0);
    expect_ev("jalr_wb", wbev(0, 2, 2, 0, 0, 1));
    run(JALR, 0, 0, 0, 0);
    dreq_n = 0;
    expect_ev("lw_mem", mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    expect_ev("lw_wb", wbev(1, 0, 1, 0, 0, 1));
    run(LW, 0, 3, 0, 0);
    chk("lw_dmem_req_cycles", 32'(dreq_n), 4);
    expect_ev("sw_mem", mk(3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    run(SW, 0, 0, 0, 0);
    expect_ev("beq_taken", mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run(BEQ, 0, 0, 1, 0);
    expect_ev("beq_not_taken", mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run(BEQ, 0, 0, 0, 0);
    expect_ev("bne_taken", mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run(BNE, 0, 0, 1, 0);
    ireq_n = 0;
    expect_ev("add_late_fetch_wb", wbev(1, 0, 0, 0, 0, 0));
    run(ADD, 3, 0, 0, 0);
    chk("late_fetch_imem_req_cycles", 32'(ireq_n), 4);
    chk("late_fetch_no_trap", 32'({trap, state}), 0);
`ifdef MULDIV_EN
    expect_ev("mul_start", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    expect_ev("mul_wb", wbev(1, 0, 3, 0, 0, 0));
    run(MUL, 0, 0, 0, 2);
    expect_ev("div_start", mk(2, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 4, 0, 0, 0));
    expect_ev("div_wb", wbev(1, 0, 3, 7, 0, 0));
    run(DIV, 0, 0, 0, 0);
`else
    expect_ev("mul_illegal", trapev(1));
    run(MUL, 0, 0, 0, 0);
    trap_reset("mul");
`endif
    expect_ev("bad_func7_trap", trapev(1));
    run(BADF7, 0, 0, 0, 0);
    trap_reset("badf7");
    expect_ev("opcode0_trap", trapev(1));
    run(32'h0, 0, 0, 0, 0);
    trap_reset("op0");
    ireq_n = 0;
    expect_ev("imem_timeout", trapev(2));
    run(ADD, 100, 0, 0, 0);
    chk("imem_timeout_wait_cycles", 32'(ireq_n), 4);
    trap_reset("itmo");
    expect_ev("dmem_timeout", trapev(3));
    run(LW, 0, 100, 0, 0);
    trap_reset("dtmo");
    instr = LW; imem_ready = 1;
    @(posedge clk); #1; imem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mem_state", 32'({state, dmem_req}), 32'h7);
    rst = 1; #1;
    chk("mid_rst_state", 32'({state, dmem_req, imem_req, trap}), 0);
    @(posedge clk); #1; rst = 0; #1;
    chk("mid_rst_release", 32'(imem_req), 1);
    expect_ev("add_after_rst", wbev(1, 0, 0, 0, 0, 0));
    run(ADD, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
